// File: rtl/l2_tag_req_sequencer.sv
// Issue stage in front of the L2 tag bank: splits one lookup into the bank's
// tag/set/state/inv-ack channels, or issues a flush, with one operation in flight.
module l2_tag_req_sequencer #(
  parameter int unsigned TAG_W       = 16,
  parameter int unsigned SET_W       = 8,
  parameter int unsigned STATE_W     = 3,
  parameter int unsigned INV_W       = 4,
  parameter int unsigned WAY_W       = 3,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [TAG_W-1:0]   req_tag,
  input  logic [SET_W-1:0]   req_set,
  input  logic               req_has_state,
  input  logic [STATE_W-1:0] req_state,
  input  logic               req_has_inv,
  input  logic [INV_W-1:0]   req_inv_cnt,
  input  logic               flush_req_valid,
  output logic               flush_req_ready,
  output logic               flush_done,
  output logic               tag_in_valid,
  input  logic               tag_in_ready,
  output logic [TAG_W-1:0]   tag_in_data,
  output logic               set_in_valid,
  input  logic               set_in_ready,
  output logic [SET_W-1:0]   set_in_data,
  output logic               state_in_valid,
  input  logic               state_in_ready,
  output logic [STATE_W-1:0] state_in_data,
  output logic               inv_ack_cnt_in_valid,
  input  logic               inv_ack_cnt_in_ready,
  output logic [INV_W-1:0]   inv_ack_cnt_in_data,
  output logic               flush_in_valid,
  input  logic               flush_in_ready,
  input  logic               flush_complete_valid,
  output logic               flush_complete_ready,
  input  logic               way_out_valid,
  output logic               way_out_ready,
  input  logic [WAY_W-1:0]   way_out_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WAY_W-1:0]   rsp_way,
  output logic               busy,
  output logic               timeout_err
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RSP, RSP, FL_ISSUE, FL_WAIT} state_e;

  localparam int unsigned      CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ARM  = CNT_W'(TIMEOUT_CYC - 2);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               tag_vld_q, set_vld_q, st_vld_q, inv_vld_q;
  logic               tag_done_q, set_done_q, st_done_q, inv_done_q;
  logic [TAG_W-1:0]   tag_q;
  logic [SET_W-1:0]   set_q;
  logic [STATE_W-1:0] st_q;
  logic [INV_W-1:0]   inv_q;
  logic               fl_vld_q, fc_rdy_q, fl_done_q;
  logic               way_rdy_q, rsp_vld_q, timeout_q;
  logic [WAY_W-1:0]   rsp_way_q;

  logic tag_done_d, set_done_d, st_done_d, inv_done_d, all_done;

  // Done view including this cycle's handshakes, so a fully parallel accept leaves ISSUE at once.
  always_comb begin
    tag_done_d = tag_done_q | (tag_vld_q & tag_in_ready);
    set_done_d = set_done_q | (set_vld_q & set_in_ready);
    st_done_d  = st_done_q  | (st_vld_q  & state_in_ready);
    inv_done_d = inv_done_q | (inv_vld_q & inv_ack_cnt_in_ready);
    all_done   = tag_done_d & set_done_d & st_done_d & inv_done_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tag_vld_q  <= 1'b0;
      set_vld_q  <= 1'b0;
      st_vld_q   <= 1'b0;
      inv_vld_q  <= 1'b0;
      tag_done_q <= 1'b0;
      set_done_q <= 1'b0;
      st_done_q  <= 1'b0;
      inv_done_q <= 1'b0;
      tag_q      <= '0;
      set_q      <= '0;
      st_q       <= '0;
      inv_q      <= '0;
      fl_vld_q   <= 1'b0;
      fc_rdy_q   <= 1'b0;
      fl_done_q  <= 1'b0;
      way_rdy_q  <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_way_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      fl_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flush_req_valid) begin
            fl_vld_q <= 1'b1;
            state_q  <= FL_ISSUE;
          end else if (req_valid) begin
            tag_q      <= req_tag;
            set_q      <= req_set;
            st_q       <= req_state;
            inv_q      <= req_inv_cnt;
            tag_vld_q  <= 1'b1;
            set_vld_q  <= 1'b1;
            st_vld_q   <= req_has_state;
            inv_vld_q  <= req_has_inv;
            tag_done_q <= 1'b0;
            set_done_q <= 1'b0;
            st_done_q  <= !req_has_state;
            inv_done_q <= !req_has_inv;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (tag_in_ready)         tag_vld_q <= 1'b0;
          if (set_in_ready)         set_vld_q <= 1'b0;
          if (state_in_ready)       st_vld_q  <= 1'b0;
          if (inv_ack_cnt_in_ready) inv_vld_q <= 1'b0;
          tag_done_q <= tag_done_d;
          set_done_q <= set_done_d;
          st_done_q  <= st_done_d;
          inv_done_q <= inv_done_d;
          if (all_done) begin
            cnt_q     <= '0;
            way_rdy_q <= 1'b1;
            state_q   <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (way_out_valid && way_rdy_q) begin
            rsp_way_q <= way_out_data;
            rsp_vld_q <= 1'b1;
            way_rdy_q <= 1'b0;
            state_q   <= RSP;
          end else if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + 1'b1;
            // Armed one count early so the error is visible while the counter reads TIMEOUT_CYC-1.
            if (cnt_q == CNT_ARM) timeout_q <= 1'b1;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_vld_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        FL_ISSUE: begin
          if (flush_in_ready) begin
            fl_vld_q <= 1'b0;
            fc_rdy_q <= 1'b1;
            state_q  <= FL_WAIT;
          end
        end
        FL_WAIT: begin
          if (flush_complete_valid) begin
            fc_rdy_q  <= 1'b0;
            fl_done_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready            = (state_q == IDLE) && !flush_req_valid;
  assign flush_req_ready      = (state_q == IDLE);
  assign busy                 = (state_q != IDLE);
  assign flush_done           = fl_done_q;
  assign tag_in_valid         = tag_vld_q;
  assign tag_in_data          = tag_q;
  assign set_in_valid         = set_vld_q;
  assign set_in_data          = set_q;
  assign state_in_valid       = st_vld_q;
  assign state_in_data        = st_q;
  assign inv_ack_cnt_in_valid = inv_vld_q;
  assign inv_ack_cnt_in_data  = inv_q;
  assign flush_in_valid       = fl_vld_q;
  assign flush_complete_ready = fc_rdy_q;
  assign way_out_ready        = way_rdy_q;
  assign rsp_valid            = rsp_vld_q;
  assign rsp_way              = rsp_way_q;
  assign timeout_err          = timeout_q;

endmodule

// File: tb/tb_l2_tag_req_sequencer.sv
// Bench for l2_tag_req_sequencer: directed and randomized lookups/flushes checked
// against a transaction-level model of the handshake rules.
module tb_l2_tag_req_sequencer;

  localparam int TAG_W = 16, SET_W = 8, STATE_W = 3, INV_W = 4, WAY_W = 3, TO = 16;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, req_has_state, req_has_inv;
  logic [TAG_W-1:0] req_tag;
  logic [SET_W-1:0] req_set;
  logic [STATE_W-1:0] req_state;
  logic [INV_W-1:0] req_inv_cnt;
  logic flush_req_valid, flush_req_ready, flush_done;
  logic tag_in_valid, tag_in_ready;
  logic [TAG_W-1:0] tag_in_data;
  logic set_in_valid, set_in_ready;
  logic [SET_W-1:0] set_in_data;
  logic state_in_valid, state_in_ready;
  logic [STATE_W-1:0] state_in_data;
  logic inv_ack_cnt_in_valid, inv_ack_cnt_in_ready;
  logic [INV_W-1:0] inv_ack_cnt_in_data;
  logic flush_in_valid, flush_in_ready, flush_complete_valid, flush_complete_ready;
  logic way_out_valid, way_out_ready;
  logic [WAY_W-1:0] way_out_data;
  logic rsp_valid, rsp_ready;
  logic [WAY_W-1:0] rsp_way;
  logic busy, timeout_err;

  always #5 clk = ~clk;

  l2_tag_req_sequencer #(
    .TAG_W(TAG_W), .SET_W(SET_W), .STATE_W(STATE_W), .INV_W(INV_W),
    .WAY_W(WAY_W), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag), .req_set(req_set),
    .req_has_state(req_has_state), .req_state(req_state),
    .req_has_inv(req_has_inv), .req_inv_cnt(req_inv_cnt),
    .flush_req_valid(flush_req_valid), .flush_req_ready(flush_req_ready), .flush_done(flush_done),
    .tag_in_valid(tag_in_valid), .tag_in_ready(tag_in_ready), .tag_in_data(tag_in_data),
    .set_in_valid(set_in_valid), .set_in_ready(set_in_ready), .set_in_data(set_in_data),
    .state_in_valid(state_in_valid), .state_in_ready(state_in_ready), .state_in_data(state_in_data),
    .inv_ack_cnt_in_valid(inv_ack_cnt_in_valid), .inv_ack_cnt_in_ready(inv_ack_cnt_in_ready),
    .inv_ack_cnt_in_data(inv_ack_cnt_in_data),
    .flush_in_valid(flush_in_valid), .flush_in_ready(flush_in_ready),
    .flush_complete_valid(flush_complete_valid), .flush_complete_ready(flush_complete_ready),
    .way_out_valid(way_out_valid), .way_out_ready(way_out_ready), .way_out_data(way_out_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_way(rsp_way),
    .busy(busy), .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;
  bit to_sticky = 1'b0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_has_state = 0; req_has_inv = 0;
    req_tag = '0; req_set = '0; req_state = '0; req_inv_cnt = '0;
    flush_req_valid = 0; tag_in_ready = 0; set_in_ready = 0; state_in_ready = 0;
    inv_ack_cnt_in_ready = 0; flush_in_ready = 0; flush_complete_valid = 0;
    way_out_valid = 0; way_out_data = '0; rsp_ready = 0;
  endtask

  // Each channel's ready rises on its (d+1)th valid cycle; way arrives on WAIT cycle d_way+1.
  task automatic do_lookup(input logic [TAG_W-1:0] tag, input logic [SET_W-1:0] set,
                           input bit hs, input logic [STATE_W-1:0] st,
                           input bit hi, input logic [INV_W-1:0] inv,
                           input int d_tag, input int d_set, input int d_st, input int d_inv,
                           input int d_way, input logic [WAY_W-1:0] way,
                           input int d_rsp, input bit stray);
    int n_tag = 0, n_set = 0, n_st = 0, n_inv = 0, n_rsp = 0, wait_k = 0;
    bit t_d = 0, s_d = 0, st_d = !hs, i_d = !hi, got_way = 0, rsp_done = 0, fin = 0;
    bit in_wait;
    req_tag = tag; req_set = set; req_has_state = hs; req_state = st;
    req_has_inv = hi; req_inv_cnt = inv; req_valid = 1; flush_req_valid = 0;
    #1;
    check_eq("req_ready_idle", req_ready, 1);
    check_eq("busy_idle", busy, 0);
    @(posedge clk); #1;
    req_valid = 0;
    check_eq("flush_done_no_pulse", flush_done, 0);
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      in_wait = t_d && s_d && st_d && i_d && !got_way;
      if (rsp_done) begin
        check_eq("busy_after_rsp", busy, 0);
        check_eq("rsp_valid_after", rsp_valid, 0);
        check_eq("timeout_final", timeout_err, to_sticky);
        fin = 1;
      end else begin
        check_eq("busy", busy, 1);
        check_eq("way_out_ready", way_out_ready, in_wait);
        check_eq("rsp_valid", rsp_valid, got_way);
        check_eq("flush_in_valid_lk", flush_in_valid, 0);
        check_eq("fc_ready_lk", flush_complete_ready, 0);
        check_eq("tag_valid", tag_in_valid, !t_d);
        check_eq("set_valid", set_in_valid, !s_d);
        check_eq("state_valid", state_in_valid, !st_d);
        check_eq("inv_valid", inv_ack_cnt_in_valid, !i_d);
        if (!t_d)  begin check_eq("tag_data", tag_in_data, tag); n_tag++; end
        if (!s_d)  begin check_eq("set_data", set_in_data, set); n_set++; end
        if (!st_d) begin check_eq("state_data", state_in_data, st); n_st++; end
        if (!i_d)  begin check_eq("inv_data", inv_ack_cnt_in_data, inv); n_inv++; end
        tag_in_ready         = (n_tag > d_tag);
        set_in_ready         = (n_set > d_set);
        state_in_ready       = (n_st > d_st);
        inv_ack_cnt_in_ready = (n_inv > d_inv);
        if (in_wait) begin
          wait_k++;
          check_eq("timeout_err", timeout_err, to_sticky || (wait_k >= TO));
          way_out_valid = (wait_k > d_way);
          way_out_data  = way_out_valid ? way : WAY_W'($urandom);
        end else begin
          check_eq("timeout_hold", timeout_err, to_sticky);
          way_out_valid = stray && ($urandom_range(0, 2) == 0);
          way_out_data  = WAY_W'($urandom);
        end
        if (got_way) begin
          if (rsp_valid) begin check_eq("rsp_way", rsp_way, way); n_rsp++; end
          rsp_ready = (n_rsp > d_rsp);
        end else begin
          rsp_ready = 1'($urandom_range(0, 1));
        end
        if (got_way && rsp_ready) rsp_done = 1;
        if (in_wait && way_out_valid) begin
          got_way = 1;
          to_sticky = to_sticky || (wait_k >= TO);
        end
        if (!t_d  && tag_in_ready)         t_d = 1;
        if (!s_d  && set_in_ready)         s_d = 1;
        if (!st_d && state_in_ready)       st_d = 1;
        if (!i_d  && inv_ack_cnt_in_ready) i_d = 1;
        @(posedge clk); #1;
      end
    end
    if (!fin) check_eq("lookup_budget", 0, 1);
    idle_inputs();
  endtask

  task automatic do_flush(input bit with_req, input int d_fi, input int d_fc);
    int n_fi = 0, n_fc = 0;
    bit fi_d = 0, fc_d = 0, fin = 0;
    flush_req_valid = 1; req_valid = with_req; req_tag = TAG_W'($urandom); req_set = SET_W'($urandom);
    #1;
    check_eq("flush_req_ready", flush_req_ready, 1);
    check_eq("req_ready_flush_prio", req_ready, 0);
    @(posedge clk); #1;
    flush_req_valid = 0; req_valid = 0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      if (fc_d) begin
        check_eq("flush_done_pulse", flush_done, 1);
        check_eq("busy_after_flush", busy, 0);
        check_eq("fc_ready_after", flush_complete_ready, 0);
        fin = 1;
      end else begin
        check_eq("busy_flush", busy, 1);
        check_eq("flush_done_early", flush_done, 0);
        check_eq("flush_in_valid", flush_in_valid, !fi_d);
        check_eq("fc_ready", flush_complete_ready, fi_d);
        check_eq("tag_valid_fl", tag_in_valid, 0);
        if (!fi_d) n_fi++;
        flush_in_ready = (n_fi > d_fi);
        if (fi_d) begin
          n_fc++;
          flush_complete_valid = (n_fc > d_fc);
        end else begin
          flush_complete_valid = 1'($urandom_range(0, 1));
        end
        if (!fi_d && flush_in_ready) fi_d = 1;
        else if (fi_d && flush_complete_valid) fc_d = 1;
        @(posedge clk); #1;
      end
    end
    if (!fin) check_eq("flush_budget", 0, 1);
    idle_inputs();
  endtask

  task automatic do_reset_mid();
    req_tag = TAG_W'($urandom); req_set = SET_W'($urandom);
    req_has_state = 0; req_has_inv = 0; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    check_eq("rm_tag_valid", tag_in_valid, 1);
    check_eq("rm_set_valid", set_in_valid, 1);
    tag_in_ready = 1; set_in_ready = 0;
    @(posedge clk); #1;
    check_eq("rm_tag_dropped", tag_in_valid, 0);
    check_eq("rm_set_pending", set_in_valid, 1);
    check_eq("rm_busy", busy, 1);
    rst = 1; tag_in_ready = 0;
    @(posedge clk); #1;
    rst = 0;
    to_sticky = 0;
    check_eq("rm_set_valid_clr", set_in_valid, 0);
    check_eq("rm_tag_valid_clr", tag_in_valid, 0);
    check_eq("rm_busy_clr", busy, 0);
    check_eq("rm_timeout_clr", timeout_err, 0);
    check_eq("rm_way_ready", way_out_ready, 0);
    check_eq("rm_req_ready", req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      check_eq("rm_no_rsp", rsp_valid, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tag_valid", tag_in_valid, 0);
    check_eq("rst_set_valid", set_in_valid, 0);
    check_eq("rst_state_valid", state_in_valid, 0);
    check_eq("rst_inv_valid", inv_ack_cnt_in_valid, 0);
    check_eq("rst_flush_valid", flush_in_valid, 0);
    check_eq("rst_way_ready", way_out_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_way", rsp_way, 0);
    check_eq("rst_tag_data", tag_in_data, 0);
    check_eq("rst_timeout", timeout_err, 0);
    check_eq("rst_flush_done", flush_done, 0);
    check_eq("rst_busy", busy, 0);
    rst = 0;
    @(posedge clk); #1;

    do_lookup(16'h1234, 8'h05, 0, '0, 0, '0, 0, 0, 0, 0, 3, 3'd5, 0, 0);
    do_lookup(TAG_W'($urandom), SET_W'($urandom), 1, 3'd3, 1, 4'd2, 4, 0, 0, 0, 2, 3'd6, 0, 0);
    do_flush(1, 2, 5);
    do_lookup(TAG_W'($urandom), SET_W'($urandom), 1, 3'd1, 0, '0, 0, 0, 0, 0, 0, 3'd2, 0, 0);
    do_lookup(TAG_W'($urandom), SET_W'($urandom), 0, '0, 1, 4'd9, 1, 2, 0, 0, 19, 3'd7, 0, 0);
    do_lookup(TAG_W'($urandom), SET_W'($urandom), 0, '0, 0, '0, 0, 0, 0, 0, 1, 3'd4, 9, 1);
    do_reset_mid();
    do_lookup(TAG_W'($urandom), SET_W'($urandom), 1, 3'd5, 1, 4'd15, 1, 1, 1, 1, 14, 3'd1, 1, 0);
    do_lookup(TAG_W'($urandom), SET_W'($urandom), 0, '0, 0, '0, 0, 0, 0, 0, 15, 3'd3, 0, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        do_flush(1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 8));
      else
        do_lookup(TAG_W'($urandom), SET_W'($urandom),
                  1'($urandom_range(0, 1)), STATE_W'($urandom),
                  1'($urandom_range(0, 1)), INV_W'($urandom),
                  $urandom_range(0, 4), $urandom_range(0, 4),
                  $urandom_range(0, 4), $urandom_range(0, 4),
                  $urandom_range(0, 20), WAY_W'($urandom),
                  $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
